// File: rtl/multizone_climate_ctrl.sv
// multizone_climate_ctrl: per-zone heat/cool hysteresis FSMs with
// minimum on/off dwell enforcement under a shared operating mode.
module multizone_climate_ctrl #(
   parameter int N_ZONES = 2,
   parameter int WIDTH   = 5,
   parameter int T_LOW   = 18,
   parameter int T_MID   = 20,
   parameter int T_HIGH  = 22,
   parameter int MIN_ON  = 3,
   parameter int MIN_OFF = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_ZONES*WIDTH-1:0]   temperature,
   input  logic [1:0]                 mode,
   input  logic [N_ZONES-1:0]         zone_en,
   output logic [N_ZONES-1:0]         heating,
   output logic [N_ZONES-1:0]         cooling,
   output logic [N_ZONES-1:0]         lockout,
   output logic                       any_active
);

   localparam int SAT = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
   // Sized so that dwell+1 never overflows at saturation.
   localparam int DW  = $clog2(SAT + 2);

   localparam logic [DW-1:0]    SAT_C = DW'(SAT);
   localparam logic [DW-1:0]    ON_C  = DW'(MIN_ON);
   localparam logic [DW-1:0]    OFF_C = DW'(MIN_OFF);
   localparam logic [DW-1:0]    ONE_C = DW'(1);
   localparam logic [WIDTH-1:0] TL_C  = WIDTH'(T_LOW);
   localparam logic [WIDTH-1:0] TM_C  = WIDTH'(T_MID);
   localparam logic [WIDTH-1:0] TH_C  = WIDTH'(T_HIGH);

   localparam logic [1:0] M_OFF  = 2'b00;
   localparam logic [1:0] M_HEAT = 2'b01;
   localparam logic [1:0] M_COOL = 2'b10;
   localparam logic [1:0] M_AUTO = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAT = 2'd1,
      COOL = 2'd2
   } state_e;

   for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
      state_e           state_q, state_d;
      logic [DW-1:0]    dwell_q, dwell_d;
      logic [WIDTH-1:0] t;
      logic [1:0]       emode;
      logic             on_ok, off_ok;
      logic             heat_ok, cool_ok;

      assign t       = temperature[g*WIDTH +: WIDTH];
      assign emode   = zone_en[g] ? mode : M_OFF;
      assign on_ok   = (dwell_q + ONE_C) >= ON_C;
      assign off_ok  = (dwell_q + ONE_C) >= OFF_C;
      assign heat_ok = (emode == M_HEAT) || (emode == M_AUTO);
      assign cool_ok = (emode == M_COOL) || (emode == M_AUTO);

      always_comb begin
         state_d = state_q;
         dwell_d = dwell_q;
         if (emode == M_OFF) begin
            state_d = IDLE;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (t <= TL_C && heat_ok && off_ok) begin
                     state_d = HEAT;
                  end else if (t >= TH_C && cool_ok && off_ok) begin
                     state_d = COOL;
                  end
               end
               HEAT: begin
                  if (on_ok && (t >= TM_C || emode == M_COOL)) begin
                     state_d = IDLE;
                  end
               end
               COOL: begin
                  if (on_ok && (t <= TM_C || emode == M_HEAT)) begin
                     state_d = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
         if (state_d != state_q) begin
            dwell_d = '0;
         end else if (dwell_q != SAT_C) begin
            dwell_d = dwell_q + ONE_C;
         end
      end

      // Reset saturates dwell so the first activation is not delayed.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= IDLE;
            dwell_q <= SAT_C;
         end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
         end
      end

      assign heating[g] = (state_q == HEAT);
      assign cooling[g] = (state_q == COOL);
      assign lockout[g] = (state_q == IDLE) && !off_ok;
   end

   assign any_active = |(heating | cooling);

endmodule

// File: tb/tb_multizone_climate_ctrl.sv
// Directed scoreboard bench for multizone_climate_ctrl:
// reset, hysteresis, min-on/off, modes, zone enables, mid-run reset.
module tb_multizone_climate_ctrl;

   logic       clk;
   logic       rst_n;
   logic [9:0] temperature;
   logic [1:0] mode;
   logic [1:0] zone_en;
   logic [1:0] heating;
   logic [1:0] cooling;
   logic [1:0] lockout;
   logic       any_active;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0] v;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [1:0] OFF  = 2'b00;
   localparam logic [1:0] HON  = 2'b01;
   localparam logic [1:0] CON  = 2'b10;
   localparam logic [1:0] AUTO = 2'b11;

   multizone_climate_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .temperature (temperature),
      .mode        (mode),
      .zone_en     (zone_en),
      .heating     (heating),
      .cooling     (cooling),
      .lockout     (lockout),
      .any_active  (any_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Expected word: {heating[1:0], cooling[1:0], lockout[1:0], any_active}
   task automatic step(input logic r, input logic [4:0] t0,
                       input logic [4:0] t1, input logic [1:0] md,
                       input logic [1:0] en, input logic [6:0] e,
                       input string tag);
      exp_t x;
      logic [6:0] obs;
      rst_n       = r;
      temperature = {t1, t0};
      mode        = md;
      zone_en     = en;
      exp_q.push_back('{v: e, tag: tag});
      @(posedge clk);
      #1;
      obs = {heating, cooling, lockout, any_active};
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL %s queue empty obs=%b", tag, obs);
      end
      x = exp_q.pop_front();
      checks++;
      assert (obs === x.v) else begin
         errors++;
         $error("FAIL %s obs=%b exp=%b", x.tag, obs, x.v);
      end
      checks++;
      assert ((heating & cooling) === 2'b00) else begin
         errors++;
         $error("FAIL %s_excl obs=%b exp=00", x.tag, heating & cooling);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      temperature = '0;
      mode        = AUTO;
      zone_en     = 2'b11;
      #1;

      // Reset held two edges, zone0 cold in AUTO
      step(0, 15, 20, AUTO, 2'b11, 7'b00_00_00_0, "rst0");
      step(0, 15, 20, AUTO, 2'b11, 7'b00_00_00_0, "rst1");
      step(1, 15, 20, AUTO, 2'b11, 7'b01_00_00_1, "rst_rel");

      // Hysteresis on zone0
      step(0, 18, 20, AUTO, 2'b11, 7'b00_00_00_0, "hy_rst");
      step(1, 18, 20, AUTO, 2'b11, 7'b01_00_00_1, "hy_18");
      step(1, 19, 20, AUTO, 2'b11, 7'b01_00_00_1, "hy_19a");
      step(1, 19, 20, AUTO, 2'b11, 7'b01_00_00_1, "hy_19b");
      step(1, 20, 20, AUTO, 2'b11, 7'b00_00_01_0, "hy_20");
      step(1, 21, 20, AUTO, 2'b11, 7'b00_00_01_0, "hy_21");
      step(1, 22, 20, AUTO, 2'b11, 7'b00_00_01_0, "hy_22lk");
      step(1, 22, 20, AUTO, 2'b11, 7'b00_00_00_0, "hy_22ok");
      step(1, 22, 20, AUTO, 2'b11, 7'b00_01_00_1, "hy_cool");

      // Min-on / min-off on zone1
      step(0, 20, 15, AUTO, 2'b11, 7'b00_00_00_0, "mo_rst");
      step(1, 20, 15, AUTO, 2'b11, 7'b10_00_00_1, "mo_heat");
      step(1, 20, 25, AUTO, 2'b11, 7'b10_00_00_1, "mo_hold1");
      step(1, 20, 25, AUTO, 2'b11, 7'b10_00_00_1, "mo_hold2");
      step(1, 20, 25, AUTO, 2'b11, 7'b00_00_10_0, "mo_idle");
      step(1, 20, 25, AUTO, 2'b11, 7'b00_00_10_0, "mo_lk2");
      step(1, 20, 25, AUTO, 2'b11, 7'b00_00_10_0, "mo_lk3");
      step(1, 20, 25, AUTO, 2'b11, 7'b00_00_00_0, "mo_unlk");
      step(1, 20, 25, AUTO, 2'b11, 7'b00_10_00_1, "mo_cool");

      // Mode gating on zone0
      step(0, 25, 20, HON,  2'b11, 7'b00_00_00_0, "md_rst");
      step(1, 25, 20, HON,  2'b11, 7'b00_00_00_0, "md_hon1");
      step(1, 25, 20, HON,  2'b11, 7'b00_00_00_0, "md_hon2");
      step(1, 25, 20, CON,  2'b11, 7'b00_01_00_1, "md_con");
      step(1, 25, 20, OFF,  2'b11, 7'b00_00_01_0, "md_off");

      // Zone independence via zone_en
      step(0, 15, 15, AUTO, 2'b10, 7'b00_00_00_0, "ze_rst");
      step(1, 15, 15, AUTO, 2'b10, 7'b10_00_00_1, "ze_10");
      step(1, 15, 15, AUTO, 2'b11, 7'b11_00_00_1, "ze_11");

      // Reset during COOL, then during lockout
      step(0, 25, 20, AUTO, 2'b01, 7'b00_00_00_0, "mr_rst");
      step(1, 25, 20, AUTO, 2'b01, 7'b00_01_00_1, "mr_cool");
      step(0, 25, 20, AUTO, 2'b01, 7'b00_00_00_0, "mr_rcool");
      step(1, 25, 20, AUTO, 2'b01, 7'b00_01_00_1, "mr_recool");
      step(1, 20, 20, AUTO, 2'b01, 7'b00_01_00_1, "mr_hold1");
      step(1, 20, 20, AUTO, 2'b01, 7'b00_01_00_1, "mr_hold2");
      step(1, 20, 20, AUTO, 2'b01, 7'b00_00_01_0, "mr_idle");
      step(0, 20, 20, AUTO, 2'b01, 7'b00_00_00_0, "mr_rlock");
      step(1, 25, 20, AUTO, 2'b01, 7'b00_01_00_1, "mr_again");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multizone_climate_ctrl.md
# multizone_climate_ctrl

- Parametrised successor to the single-zone air-conditioning controller: drives independent heat/cool decisions for `N_ZONES` zones.
- Each zone runs its own three-state hysteresis machine from the configurable thresholds `T_LOW`, `T_MID` and `T_HIGH`.
- Each zone enforces a minimum on-time and a minimum off-time, so actuators cannot short-cycle.
- A shared operating mode and a per-zone enable sit on top of this; the block feeds the actuator drivers.

## Interface
- `N_ZONES`, default 2: number of independent zones.
- `WIDTH`, default 5: temperature width in bits, unsigned.
- `T_LOW`, default 18: heat-on threshold; the zone starts heating when temp <= `T_LOW`.
- `T_MID`, default 20: return-to-idle threshold.
- `T_HIGH`, default 22: cool-on threshold; the zone starts cooling when temp >= `T_HIGH`.
- `MIN_ON`, default 3: minimum number of cycles HEAT or COOL stays asserted. Values 0 and 1 both mean no constraint.
- `MIN_OFF`, default 4: minimum number of cycles in IDLE before re-activation. Values 0 and 1 both mean no constraint.
- Legal parameter sets require `T_LOW < T_MID < T_HIGH` and all thresholds < 2^`WIDTH`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `temperature`  in  `N_ZONES`*`WIDTH`  packed temperatures; zone i occupies bits [i*`WIDTH` +: `WIDTH`].
- `mode`  in  2  shared mode: 00 OFF, 01 HEAT_ONLY, 10 COOL_ONLY, 11 AUTO.
- `zone_en`  in  `N_ZONES`  per-zone enable; 0 treats that zone as mode OFF.
- `heating`  out  `N_ZONES`  bit i = zone i in HEAT.
- `cooling`  out  `N_ZONES`  bit i = zone i in COOL.
- `lockout`  out  `N_ZONES`  bit i = zone i in IDLE with the `MIN_OFF` time not yet elapsed.
- `any_active`  out  1  OR of all `heating` and `cooling` bits.

## Operation
- Each zone has a state register {IDLE, HEAT, COOL}; {`heating[i]`, `cooling[i]`} is decoded directly from it.
  - The pair is never 11.
  - There is no direct HEAT<->COOL transition; a zone always passes through IDLE.
- Each zone has a dwell counter.
  - It is cleared to 0 on the edge at which the state changes.
  - Otherwise it increments each edge and saturates at max(`MIN_ON`, `MIN_OFF`).
- on_ok(i) = dwell+1 >= `MIN_ON`. off_ok(i) = dwell+1 >= `MIN_OFF`.
- Effective mode of zone i is OFF if `zone_en[i]`=0, otherwise `mode`.
- Transition priority per zone, evaluated each edge with t = the zone's temperature:
  - 1. Effective mode OFF: next state is IDLE unconditionally. This bypasses `MIN_ON`; it is the safety override.
  - 2. IDLE -> HEAT when t <= `T_LOW`, mode is HEAT_ONLY or AUTO, and off_ok.
  - 3. IDLE -> COOL when t >= `T_HIGH`, mode is COOL_ONLY or AUTO, and off_ok.
  - 4. HEAT -> IDLE when on_ok and either t >= `T_MID` or mode is COOL_ONLY.
  - 5. COOL -> IDLE when on_ok and either t <= `T_MID` or mode is HEAT_ONLY.
  - 6. Otherwise the zone holds its state.
- Comparisons are unsigned, full `WIDTH`; there is no wrap-around.
- `lockout[i]` = (state==IDLE) && !off_ok. It is registered-state-derived: no dependency on `temperature`.
- Zones are fully independent; only `mode` is shared.

## Timing
- Reset (`rst_n`=0 at an edge):
  - All zones go to IDLE and dwell counters to saturation.
  - After that edge, `heating`=0, `cooling`=0, `lockout`=0 and `any_active`=0.
  - A zone may activate at the first edge after reset is released.
- Reset asserted mid-HEAT or mid-COOL: outputs clear after that edge regardless of `MIN_ON`.
- Latency: inputs are sampled at edge k; outputs reflect the new state after edge k.
  - All outputs are registered-state decodes; there is no combinational input-to-output path.
- Minimum on-time: with `MIN_ON`=M >= 1, a zone entering HEAT or COOL holds it for at least M cycles unless overridden by effective mode OFF or by reset.
- Minimum off-time: after leaving HEAT or COOL, the zone is in IDLE for at least `MIN_OFF` cycles.
  - Exception: the first activation after reset is not delayed.
  - `lockout` is high for the first `MIN_OFF`-1 of those cycles.
- Simultaneous change of `mode` and `temperature`: the priority order above applies; OFF always wins.
- t exactly at a threshold:
  - t = `T_LOW` starts heating.
  - t = `T_HIGH` starts cooling.
  - t = `T_MID` ends either mode.
- Temperature between `T_LOW` and `T_HIGH` while IDLE: the zone holds IDLE.

## Test plan
Defaults apply throughout (N=2, W=5, 18/20/22, `MIN_ON`=3, `MIN_OFF`=4).
- Reset: `rst_n`=0 for 2 cycles with zone0 temp=15 and AUTO -> all outputs 0 during reset; `heating`=01 one edge after release.
- Hysteresis: zone0 temp sequence 18, 19, 19, 20, 21, 22 in AUTO.
  - HEAT from the first edge.
  - IDLE after the edge sampling 20.
  - `lockout[0]`=1 for 3 cycles.
  - COOL after the edge sampling 22, once lockout has cleared; never 11.
- Min-on: zone1 in HEAT at temp=15, temp=25 applied one cycle after entry -> `heating[1]` stays high for exactly 3 cycles total.
  - It then goes IDLE.
  - COOL follows no earlier than 4 cycles later.
- Modes: temp=25 in HEAT_ONLY -> zone stays IDLE.
  - Switch to COOL_ONLY -> COOL next edge.
  - Switch to OFF -> IDLE next edge despite `MIN_ON`.
- Zone independence: `zone_en`=10, both temps=15, AUTO -> `heating`=10 and zone0 idle.
  - Set `zone_en`=11 -> `heating`=11 next edge.
- Reset mid-operation: assert `rst_n`=0 while zone0 is COOL and in lockout -> `cooling`=0 and `lockout`=0 after that edge.
  - On release with temp=25, zone0 re-enters COOL immediately.
